// File: rtl/main_datapath.sv
// main_datapath -- UART-controlled 8-bit ALU.
//
// A command arrives on uartRx as three bytes (operand A, operand B, opcode).
// The ALU result is sent back as one byte on uartTx (8N1, LSB first).
//
// Optional feature macro: ALU_SHIFT_EN
//   defined   : opcodes 0x02 (SRL) and 0x03 (SRA) shift A by B[2:0]
//   undefined : 0x02/0x03 behave like any undefined opcode (result 0x00),
//               and no shifter is built
//
// Ports:
//   clk              system clock, rising edge
//   reset            synchronous, active-high
//   clk70            reserved clock pin, intentionally unused
//   uartRx           serial input (idle high)
//   uartTx           serial output (idle high)
//   ALUzero          last result == 0 (updated in EXEC)
//   ALUOverflow      signed overflow of last ADD/SUB (updated in EXEC)
//   ledIdle          control FSM is in IDLE
//   sentFlag         one-cycle pulse when a result byte finishes
//   notStartUartTx   active-low transmit-start strobe (low during EXEC)
//   ledDataAvailable command in progress (WAIT_B, WAIT_OP, EXEC)
//   sendCounter      number of result bytes sent, wraps at 255
module main_datapath #(
    parameter int CLK_FREQ     = 12500000,
    parameter int BAUD         = 19200,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clk70,
    input  logic       uartRx,
    output logic       uartTx,
    output logic       ALUzero,
    output logic       ALUOverflow,
    output logic       ledIdle,
    output logic       sentFlag,
    output logic       notStartUartTx,
    output logic       ledDataAvailable,
    output logic [7:0] sendCounter
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {IDLE, WAIT_B, WAIT_OP, EXEC, SEND} state_t;

    state_t state, state_nxt;

    logic unused_clk70;
    assign unused_clk70 = clk70;

    // Returns {overflow, result}.
    function automatic logic [8:0] alu_calc(input logic [7:0] opa,
                                            input logic [7:0] opb,
                                            input logic [7:0] op);
        logic        [7:0] r;
        logic              v;
        logic signed [7:0] sa;
        r  = '0;
        v  = 1'b0;
        sa = opa;
        case (op)
            8'h20: begin
                r = opa + opb;
                v = (opa[7] == opb[7]) && (r[7] != opa[7]);
            end
            8'h22: begin
                r = opa - opb;
                v = (opa[7] != opb[7]) && (r[7] != opa[7]);
            end
            8'h24: r = opa & opb;
            8'h25: r = opa | opb;
            8'h26: r = opa ^ opb;
            8'h27: r = ~(opa | opb);
`ifdef ALU_SHIFT_EN
            8'h02: r = opa >> opb[2:0];
            8'h03: r = sa >>> opb[2:0];
`endif
            default: r = '0;
        endcase
        return {v, r};
    endfunction

    // ---- receiver: synchronizer plus falling-edge detect ----
    logic rx_s1, rx_s2, rx_s3;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_s3 <= 1'b1;
        end else begin
            rx_s1 <= uartRx;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
        end
    end

    // rx_bit: 0 = start-bit check at half a bit, 1..8 = data, 9 = stop
    logic             rx_busy;
    logic             rx_done;
    logic [3:0]       rx_bit;
    logic [CNT_W-1:0] rx_cnt;
    logic [7:0]       rx_sh;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_busy <= 1'b0;
            rx_done <= 1'b0;
            rx_bit  <= '0;
            rx_cnt  <= '0;
        end else begin
            rx_done <= 1'b0;
            if (!rx_busy) begin
                if (rx_s3 && !rx_s2) begin
                    rx_busy <= 1'b1;
                    rx_bit  <= '0;
                    rx_cnt  <= '0;
                end
            end else if (rx_cnt != ((rx_bit == 4'd0) ? HALF_LAST : BIT_LAST)) begin
                rx_cnt <= rx_cnt + 1'b1;
            end else begin
                rx_cnt <= '0;
                if (rx_bit == 4'd0) begin
                    // line back high at mid start bit: treat as a glitch
                    if (rx_s2) rx_busy <= 1'b0;
                    else       rx_bit  <= 4'd1;
                end else if (rx_bit <= 4'd8) begin
                    rx_sh  <= {rx_s2, rx_sh[7:1]};
                    rx_bit <= rx_bit + 4'd1;
                end else begin
                    // a low stop bit is a framing error: byte is dropped
                    rx_busy <= 1'b0;
                    rx_done <= rx_s2;
                end
            end
        end
    end

    // ---- control FSM ----
    logic       tx_done;
    logic [7:0] opnd_a, opnd_b, opcode;
    logic [8:0] alu_out;

    assign alu_out = alu_calc(opnd_a, opnd_b, opcode);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt        = state;
        ledIdle          = 1'b0;
        ledDataAvailable = 1'b0;
        notStartUartTx   = 1'b1;
        sentFlag         = 1'b0;
        case (state)
            IDLE: begin
                ledIdle = 1'b1;
                if (rx_done) state_nxt = WAIT_B;
            end
            WAIT_B: begin
                ledDataAvailable = 1'b1;
                if (rx_done) state_nxt = WAIT_OP;
            end
            WAIT_OP: begin
                ledDataAvailable = 1'b1;
                if (rx_done) state_nxt = EXEC;
            end
            EXEC: begin
                ledDataAvailable = 1'b1;
                notStartUartTx   = 1'b0;
                state_nxt        = SEND;
            end
            SEND: begin
                if (tx_done) begin
                    sentFlag  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rx_done) begin
            case (state)
                IDLE:    opnd_a <= rx_sh;
                WAIT_B:  opnd_b <= rx_sh;
                WAIT_OP: opcode <= rx_sh;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ALUzero     <= 1'b0;
            ALUOverflow <= 1'b0;
            sendCounter <= '0;
        end else begin
            if (state == EXEC) begin
                ALUzero     <= (alu_out[7:0] == 8'h00);
                ALUOverflow <= alu_out[8];
            end
            if (sentFlag) sendCounter <= sendCounter + 8'd1;
        end
    end

    // ---- transmitter: loaded on the edge that leaves EXEC ----
    logic             tx_busy;
    logic [3:0]       tx_bit;
    logic [CNT_W-1:0] tx_cnt;
    logic [7:0]       tx_sh;

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_busy <= 1'b0;
            tx_done <= 1'b0;
            tx_bit  <= '0;
            tx_cnt  <= '0;
            uartTx  <= 1'b1;
        end else begin
            tx_done <= 1'b0;
            if (state == EXEC) begin
                tx_busy <= 1'b1;
                tx_bit  <= '0;
                tx_cnt  <= '0;
                tx_sh   <= alu_out[7:0];
                uartTx  <= 1'b0;
            end else if (tx_busy) begin
                if (tx_cnt != BIT_LAST) begin
                    tx_cnt <= tx_cnt + 1'b1;
                end else begin
                    tx_cnt <= '0;
                    if (tx_bit < 4'd8) begin
                        uartTx <= tx_sh[0];
                        tx_sh  <= {1'b0, tx_sh[7:1]};
                        tx_bit <= tx_bit + 4'd1;
                    end else if (tx_bit == 4'd8) begin
                        uartTx <= 1'b1;
                        tx_bit <= 4'd9;
                    end else begin
                        tx_busy <= 1'b0;
                        tx_done <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_main_datapath.sv
// Testbench for main_datapath: table-driven commands, randomized commands
// against a behavioural ALU model, and hand-written corner sequences
// (single byte, framing error, glitch, reset during transmission).
// A short bit period is used so the run stays small.
module tb_main_datapath;

    localparam int CLK_FREQ = 320;
    localparam int BAUD     = 10;
    localparam int CPB      = CLK_FREQ / BAUD;

`ifdef ALU_SHIFT_EN
    localparam bit SHIFT_EN = 1'b1;
`else
    localparam bit SHIFT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clk70 = 1'b0;
    logic       uartRx = 1'b1;
    logic       uartTx, ALUzero, ALUOverflow, ledIdle, sentFlag;
    logic       notStartUartTx, ledDataAvailable;
    logic [7:0] sendCounter;

    always #5 clk = ~clk;

    main_datapath #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clk(clk),
        .reset(reset),
        .clk70(clk70),
        .uartRx(uartRx),
        .uartTx(uartTx),
        .ALUzero(ALUzero),
        .ALUOverflow(ALUOverflow),
        .ledIdle(ledIdle),
        .sentFlag(sentFlag),
        .notStartUartTx(notStartUartTx),
        .ledDataAvailable(ledDataAvailable),
        .sendCounter(sendCounter)
    );

    int         checks = 0;
    int         failures = 0;
    int         nstart_cnt = 0;
    int         sent_cnt = 0;
    int         exp_count = 0;
    logic [8:0] txq[$];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Pulse counters for the strobes.
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            if (!notStartUartTx) nstart_cnt++;
            if (sentFlag) sent_cnt++;
        end
    end

    // Serial decoder on uartTx; queues {stop, data}.
    initial begin
        logic [7:0] d;
        logic       s;
        d = '0;
        forever begin
            @(negedge clk);
            if (!reset && uartTx == 1'b0) begin
                repeat (CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    d[i] = uartTx;
                end
                repeat (CPB) @(negedge clk);
                s = uartTx;
                txq.push_back({s, d});
            end
        end
    end

    task automatic send_byte(input logic [7:0] d, input logic stop);
        logic [9:0] fr;
        fr = {stop, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uartRx = fr[i];
            repeat (CPB) @(negedge clk);
        end
        uartRx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Reference ALU computed with plain integer arithmetic.
    function automatic void model(input logic [7:0] a, input logic [7:0] b,
                                  input logic [7:0] op, output logic [7:0] r,
                                  output logic z, output logic o);
        int sa, sb, s, k;
        sa = (a > 127) ? int'(a) - 256 : int'(a);
        sb = (b > 127) ? int'(b) - 256 : int'(b);
        k  = int'(b) % 8;
        r  = 8'h00;
        o  = 1'b0;
        case (op)
            8'h20: begin s = sa + sb; r = 8'((int'(a) + int'(b)) % 256); o = (s > 127) || (s < -128); end
            8'h22: begin s = sa - sb; r = 8'((int'(a) - int'(b) + 256) % 256); o = (s > 127) || (s < -128); end
            8'h24: r = a & b;
            8'h25: r = a | b;
            8'h26: r = a ^ b;
            8'h27: r = ~(a | b);
            8'h02: if (SHIFT_EN) r = 8'(int'(a) / (1 << k));
            8'h03: if (SHIFT_EN) begin
                s = (sa >= 0) ? sa / (1 << k) : -((-sa + (1 << k) - 1) / (1 << k));
                r = 8'((s + 256) % 256);
            end
            default: r = 8'h00;
        endcase
        z = (r == 8'h00);
    endfunction

    task automatic run_cmd(input string nm, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] op, input logic [7:0] er,
                           input logic ez, input logic eo);
        int         ns0, sc0;
        bit         seen;
        logic [8:0] fr;
        ns0 = nstart_cnt;
        sc0 = sent_cnt;
        send_byte(a, 1'b1);
        chk({nm, "_busy"}, ledDataAvailable, 1);
        send_byte(b, 1'b1);
        send_byte(op, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 16 * CPB && !seen; i++) begin
            @(negedge clk);
            if (sentFlag) seen = 1'b1;
        end
        chk({nm, "_sentflag_seen"}, seen, 1);
        @(negedge clk);
        chk({nm, "_sent_pulses"}, sent_cnt - sc0, 1);
        chk({nm, "_nstart_pulses"}, nstart_cnt - ns0, 1);
        fr = (txq.size() > 0) ? txq.pop_front() : 9'h000;
        chk({nm, "_txframe"}, fr, {1'b1, er});
        chk({nm, "_zero"}, ALUzero, ez);
        chk({nm, "_ovf"}, ALUOverflow, eo);
        exp_count = (exp_count + 1) % 256;
        chk({nm, "_count"}, sendCounter, exp_count);
        chk({nm, "_idle"}, ledIdle, 1);
    endtask

    typedef struct packed {
        logic [7:0] a, b, op, res;
        logic       z, o;
    } vec_t;

    initial begin
        vec_t       vecs[11];
        logic [7:0] ops[8];
        logic [7:0] ra, rb, rop, er;
        logic       ez, eo;
        int         ns0, sc0;

        vecs[0]  = '{8'h05, 8'h03, 8'h20, 8'h08, 1'b0, 1'b0};
        vecs[1]  = '{8'h7F, 8'h01, 8'h20, 8'h80, 1'b0, 1'b1};
        vecs[2]  = '{8'h10, 8'h10, 8'h22, 8'h00, 1'b1, 1'b0};
        vecs[3]  = '{8'h80, 8'h01, 8'h22, 8'h7F, 1'b0, 1'b1};
        vecs[4]  = '{8'hF0, 8'h0F, 8'h24, 8'h00, 1'b1, 1'b0};
        vecs[5]  = '{8'hF0, 8'h0F, 8'h25, 8'hFF, 1'b0, 1'b0};
        vecs[6]  = '{8'hAA, 8'hFF, 8'h26, 8'h55, 1'b0, 1'b0};
        vecs[7]  = '{8'h00, 8'h00, 8'h27, 8'hFF, 1'b0, 1'b0};
        vecs[8]  = '{8'h80, 8'h02, 8'h03, (SHIFT_EN ? 8'hE0 : 8'h00), !SHIFT_EN, 1'b0};
        vecs[9]  = '{8'h80, 8'h03, 8'h02, (SHIFT_EN ? 8'h10 : 8'h00), !SHIFT_EN, 1'b0};
        vecs[10] = '{8'h12, 8'h34, 8'h99, 8'h00, 1'b1, 1'b0};
        ops = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h02, 8'h03};

        // Reset state
        repeat (5) @(negedge clk);
        chk("rst_uartTx", uartTx, 1);
        chk("rst_nstart", notStartUartTx, 1);
        chk("rst_sentFlag", sentFlag, 0);
        chk("rst_zero", ALUzero, 0);
        chk("rst_ovf", ALUOverflow, 0);
        chk("rst_count", sendCounter, 0);
        chk("rst_idle", ledIdle, 1);
        chk("rst_avail", ledDataAvailable, 0);
        reset = 1'b0;
        @(negedge clk);

        // Single byte: command starts, nothing is transmitted
        send_byte(8'h63, 1'b1);
        chk("one_idle", ledIdle, 0);
        chk("one_avail", ledDataAvailable, 1);
        repeat (4 * CPB) @(negedge clk);
        chk("one_notx", txq.size(), 0);
        chk("one_uartTx", uartTx, 1);
        chk("one_count", sendCounter, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("one_rst_idle", ledIdle, 1);

        // Table of commands
        for (int i = 0; i < 11; i++)
            run_cmd($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].op,
                    vecs[i].res, vecs[i].z, vecs[i].o);

        // Framing error: byte discarded
        send_byte(8'h55, 1'b0);
        repeat (2 * CPB) @(negedge clk);
        chk("frm_idle", ledIdle, 1);
        chk("frm_avail", ledDataAvailable, 0);

        // 100 ns low glitch
        uartRx = 1'b0;
        repeat (10) @(negedge clk);
        uartRx = 1'b1;
        repeat (12 * CPB) @(negedge clk);
        chk("glitch_idle", ledIdle, 1);
        chk("glitch_notx", txq.size(), 0);

        // Randomized commands against the model
        for (int i = 0; i < 20; i++) begin
            ra  = 8'($urandom_range(0, 255));
            rb  = 8'($urandom_range(0, 255));
            rop = ($urandom_range(0, 9) < 8) ? ops[$urandom_range(0, 7)]
                                             : 8'($urandom_range(0, 255));
            model(ra, rb, rop, er, ez, eo);
            run_cmd($sformatf("rnd%0d_%02h_%02h_%02h", i, ra, rb, rop), ra, rb, rop, er, ez, eo);
        end

        // Reset during result transmission (result 0x00 keeps the line low)
        ns0 = nstart_cnt;
        sc0 = sent_cnt;
        send_byte(8'h10, 1'b1);
        send_byte(8'h10, 1'b1);
        send_byte(8'h22, 1'b1);
        chk("txrst_started", nstart_cnt - ns0, 1);
        repeat (2 * CPB) @(negedge clk);
        chk("txrst_line_low", uartTx, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("txrst_uartTx", uartTx, 1);
        chk("txrst_count", sendCounter, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (14 * CPB) @(negedge clk);
        chk("txrst_nosent", sent_cnt - sc0, 0);
        chk("txrst_idle", ledIdle, 1);
        chk("txrst_uartTx_idle", uartTx, 1);
        exp_count = 0;
        txq.delete();

        // Recovery after reset
        run_cmd("post_rst", 8'h05, 8'h03, 8'h20, 8'h08, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/main_datapath.md
# main_datapath

UART-controlled 8-bit ALU datapath for the FPGA top level. It receives a three-byte command over a 19200-baud serial line: operand A, operand B, then opcode. It computes the result in an 8-bit ALU and transmits the result byte back on the serial output. Status outputs drive board LEDs and debug pins.

## Interface
Parameters:
- CLK_FREQ, 12500000, system clock frequency in Hz.
- BAUD, 19200, serial bit rate.
- CLKS_PER_BIT, CLK_FREQ/BAUD (651), clock cycles per serial bit.

Ports:
- clk  in  1  single system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- clk70  in  1  reserved phase-shifted clock pin; unused, drives no logic.
- uartRx  in  1  serial input; idle high.
- uartTx  out  1  serial output; idle high.
- ALUzero  out  1  last result == 0.
- ALUOverflow  out  1  signed overflow of last ADD/SUB.
- ledIdle  out  1  FSM in IDLE.
- sentFlag  out  1  one-cycle pulse when a result byte finishes transmitting.
- notStartUartTx  out  1  active-low transmit-start strobe.
- ledDataAvailable  out  1  command in progress (byte A received, result not yet launched).
- sendCounter  out  8  count of result bytes transmitted.

## Operation
- Receiver:
  - 2-flop synchronizer on uartRx.
  - Falling edge starts a frame. The line is re-checked at half a bit (325 cycles); if it is high, abort (glitch).
  - Data bits are sampled every 651 cycles, LSB first.
  - The stop bit is sampled at mid-bit. Stop = 1 gives a one-cycle rx_done; stop = 0 is a framing error and the byte is discarded.
- Transmitter: start bit 0, 8 data bits LSB first, stop bit 1, each bit 651 cycles. A frame is 6510 cycles.
- Control FSM states: IDLE, WAIT_B, WAIT_OP, EXEC, SEND.
  - IDLE -rx_done-> WAIT_B: latch A.
  - WAIT_B -rx_done-> WAIT_OP: latch B.
  - WAIT_OP -rx_done-> EXEC: latch opcode.
  - EXEC: register result and flags, pulse notStartUartTx low, go to SEND.
  - SEND: on tx done, pulse sentFlag, increment sendCounter, go to IDLE.
  - Bytes received while in EXEC/SEND are dropped.
- ALU opcodes (8-bit, unsigned wrap):
  - 0x20 ADD.
  - 0x22 SUB (A−B).
  - 0x24 AND.
  - 0x25 OR.
  - 0x26 XOR.
  - 0x27 NOR.
  - 0x02 SRL (A>>B[2:0]).
  - 0x03 SRA.
  - Any other opcode gives result 0x00.
- ALU flags:
  - ALUOverflow: set for ADD when the operands have equal sign and the result sign differs; for SUB when the operands' signs differ and the result sign differs from A; 0 for all other ops.
  - ALUzero = (result == 0).
  - Both flags update only in EXEC and hold until the next EXEC.
- sendCounter wraps 255 → 0.
- ledIdle = (state == IDLE).
- ledDataAvailable = state ∈ {WAIT_B, WAIT_OP, EXEC}.

## Timing
- Reset values:
  - uartTx = 1, notStartUartTx = 1, sentFlag = 0.
  - ALUzero = 0, ALUOverflow = 0, sendCounter = 0.
  - ledIdle = 1, ledDataAvailable = 0.
  - FSM in IDLE; receiver and transmitter idle.
- rx_done occurs at the stop-bit mid-sample, about 9.5 bit times after the start edge plus 2 synchronizer cycles.
- EXEC is the cycle after the opcode rx_done. notStartUartTx is low for exactly that one cycle. uartTx goes low on the next edge.
- sentFlag pulses one cycle after the stop bit's 651st cycle. sendCounter updates on the same edge.
- Reset mid-frame: receive or transmit is aborted, uartTx is high on the next edge, and partial bytes are lost.

## Configuration
- ALU_SHIFT_EN defined: SRL/SRA (0x02/0x03) implemented.
- ALU_SHIFT_EN undefined: 0x02/0x03 are treated as undefined and give result 0x00 with ALUzero = 1; the shifter logic is not built.

## Test plan
- Reset, then send the single byte 0x63: ledIdle → 0 and ledDataAvailable → 1 after rx_done; no transmission; sendCounter stays 0.
- Send 0x05, 0x03, 0x20: uartTx frame carries 0x08; ALUzero = 0, ALUOverflow = 0; sentFlag pulses; sendCounter = 1; ledIdle returns to 1.
- Send 0x7F, 0x01, 0x20: result 0x80, ALUOverflow = 1. Then send 0x10, 0x10, 0x22: result 0x00, ALUzero = 1, ALUOverflow = 0.
- Send A = 0x55 with the stop bit driven 0: byte discarded and FSM stays IDLE. A 100 ns low glitch on uartRx produces no rx_done.
- Assert reset during result transmission: uartTx = 1 next cycle, sendCounter = 0, no sentFlag.
- With ALU_SHIFT_EN, 0x80, 0x02, 0x03 gives 0xE0; without it, the same command gives 0x00.
